// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART echo controller: transmit FSM states
// and the default buffer depth / inter-byte gap.
package uart_ctrl_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_GAP_CYCLES = 0;
  localparam int GAP_CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/occupancy values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers, cleared by reset so buffered data is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART echo controller: buffers received bytes and feeds them back to the
// transmitter in arrival order, with an optional idle gap after each byte.
module uart_fifo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  rx_done_sig,
  input  logic [7:0]            rx_data,
  input  logic                  tx_done_sig,
  input  logic                  clr_overrun,
  output logic                  rx_en_sig,
  output logic                  tx_en_sig,
  output logic [7:0]            tx_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                  overrun
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  tx_state_e            state_q;
  logic                 tx_en_q;
  logic [7:0]           tx_data_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic                 overrun_q;
  logic                 rx_en_q;

  logic [CW-1:0] count;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          pop;
  logic          drop;

  // The transmitter only takes a byte from the buffer while it is idle.
  assign pop  = (state_q == IDLE) && (count != '0);
  assign drop = rx_done_sig && fifo_full && !pop;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_ni  (rst_n),
    .push_i  (rx_done_sig),
    .wdata_i (rx_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (count),
    .full_o  (fifo_full)
  );

  // Transmit sequencer: pop into the data register, raise enable, hold until done, then optional gap.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q <= fifo_head;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          tx_en_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_done_sig) begin
            tx_en_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag and registered receive enable; a new drop wins over a clear.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      rx_en_q   <= 1'b0;
    end else begin
      if (drop)             overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
      rx_en_q <= (count < CW'(DEPTH));
    end
  end

  assign rx_en_sig  = rx_en_q;
  assign tx_en_sig  = tx_en_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: one instance with no inter-byte gap and
// one with a 4-cycle gap, driven by the same stimulus.
module tb_uart_fifo_ctrl;

  logic       sysclk = 1'b0;
  logic       rstN = 1'b1;
  logic       rxDone = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       txDone = 1'b0;
  logic       clrOverrun = 1'b0;

  logic       rxEn, txEn, overrun;
  logic [7:0] txData;
  logic [3:0] fifoCount;
  logic       rxEnG, txEnG, overrunG;
  logic [7:0] txDataG;
  logic [3:0] fifoCountG;

  int checkCount = 0;
  int passCount = 0;

  int         pushCyc[$];
  logic [7:0] pushVal[$];
  logic [7:0] got[$];
  logic [7:0] expBytes[$];
  int         maxCount;
  int         overrunSeen;
  int         stableErr;

  always #5 sysclk = ~sysclk;

  uart_fifo_ctrl #(.DEPTH(8), .GAP_CYCLES(0)) dut (
    .sysclk      (sysclk),
    .rst_n       (rstN),
    .rx_done_sig (rxDone),
    .rx_data     (rxData),
    .tx_done_sig (txDone),
    .clr_overrun (clrOverrun),
    .rx_en_sig   (rxEn),
    .tx_en_sig   (txEn),
    .tx_data     (txData),
    .fifo_count  (fifoCount),
    .overrun     (overrun)
  );

  uart_fifo_ctrl #(.DEPTH(8), .GAP_CYCLES(4)) dutGap (
    .sysclk      (sysclk),
    .rst_n       (rstN),
    .rx_done_sig (rxDone),
    .rx_data     (rxData),
    .tx_done_sig (txDone),
    .clr_overrun (clrOverrun),
    .rx_en_sig   (rxEnG),
    .tx_en_sig   (txEnG),
    .tx_data     (txDataG),
    .fifo_count  (fifoCountG),
    .overrun     (overrunG)
  );

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Hold one set of inputs for exactly one clock edge
  task automatic applyStimulus(input logic rxD, input logic [7:0] data,
                               input logic txD, input logic clr);
    rxDone = rxD;
    rxData = data;
    txDone = txD;
    clrOverrun = clr;
    tick();
    rxDone = 1'b0;
    txDone = 1'b0;
    clrOverrun = 1'b0;
  endtask

  // Assert reset asynchronously, hold for two edges, release and let rx_en rise
  task automatic doReset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    pushCyc.delete();
    pushVal.delete();
    expBytes.delete();
  endtask

  // Cycle-driven echo loop: pushes per schedule, answers each tx_en with tx_done after a delay
  task automatic runEcho(input int cycles, input int doneDelay);
    int idx = 0;
    int doneAt = -1;
    logic prevEn = 1'b0;
    logic [7:0] held = 8'h00;
    got.delete();
    maxCount = 0;
    overrunSeen = 0;
    stableErr = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
      if (overrun) overrunSeen = 1;
      if (txEn && !prevEn) begin
        got.push_back(txData);
        held = txData;
        doneAt = cyc + doneDelay;
      end else if (txEn && (txData != held)) begin
        stableErr++;
      end
      prevEn = txEn;
      if (idx < pushCyc.size()) begin
        if (pushCyc[idx] == cyc) begin
          rxDone = 1'b1;
          rxData = pushVal[idx];
          idx++;
        end
      end
      txDone = (cyc == doneAt);
      tick();
      rxDone = 1'b0;
      txDone = 1'b0;
    end
  endtask

  // Compare the transmitted byte stream against the expected list
  task automatic checkStream(input string tag);
    checkOutput({tag, " count"}, got.size(), expBytes.size());
    for (int i = 0; i < expBytes.size(); i++) begin
      if (i < got.size()) checkOutput($sformatf("%s byte%0d", tag, i), got[i], expBytes[i]);
    end
    checkOutput({tag, " tx_data stable"}, stableErr, 0);
  endtask

  initial begin
    int n;
    int lowA, lowG;
    logic seenA, seenG;

    // Reset values, observed asynchronously before any clock edge
    #1 rstN = 1'b0;
    #1;
    checkOutput("reset tx_en", txEn, 0);
    checkOutput("reset tx_data", txData, 8'h00);
    checkOutput("reset fifo_count", fifoCount, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset rx_en", rxEn, 0);
    checkOutput("reset rx_en gap inst", rxEnG, 0);
    tick();
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("rx_en before first edge", rxEn, 0);
    tick();
    checkOutput("rx_en after first edge", rxEn, 1);

    // Single byte: rx at N gives tx_en at N+3; tx_done outside SEND is ignored
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("single count after push", fifoCount, 1);
    checkOutput("single tx_en N+1", txEn, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single tx_en N+2", txEn, 0);
    checkOutput("single count after pop", fifoCount, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single tx_en N+3", txEn, 1);
    checkOutput("single tx_data", txData, 8'hA5);
    tick();
    tick();
    tick();
    checkOutput("single tx_en held", txEn, 1);
    checkOutput("single tx_data held", txData, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single tx_en after done", txEn, 0);
    checkOutput("single count final", fifoCount, 0);
    tick();
    tick();
    tick();
    checkOutput("single no retransmit", txEn, 0);

    // Burst of five back-to-back bytes, tx_done 20 cycles after each tx_en
    doReset();
    for (int i = 0; i < 5; i++) begin
      pushCyc.push_back(i);
      pushVal.push_back(8'(i + 1));
      expBytes.push_back(8'(i + 1));
    end
    runEcho(200, 20);
    checkStream("burst");
    checkOutput("burst overrun", overrunSeen, 0);

    // Overflow: the first byte goes to the transmitter, bytes 2..9 fill the FIFO, byte 10 drops
    doReset();
    for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
    checkOutput("ovf fifo_count", fifoCount, 8);
    checkOutput("ovf rx_en", rxEn, 0);
    checkOutput("ovf overrun", overrun, 1);
    checkOutput("ovf tx_data", txData, 8'h01);
    tick();
    checkOutput("ovf overrun sticky", overrun, 1);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b1);
    checkOutput("ovf drop beats clear", overrun, 1);
    checkOutput("ovf count after drop", fifoCount, 8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf overrun cleared", overrun, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ovf tx_en after done", txEn, 0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0);
    checkOutput("full push+pop count", fifoCount, 8);
    checkOutput("full push+pop overrun", overrun, 0);
    checkOutput("full push+pop tx_data", txData, 8'h02);
    for (int k = 2; k <= 9; k++) expBytes.push_back(8'(k));
    expBytes.push_back(8'h0B);
    runEcho(100, 2);
    checkStream("ovf drain");

    // Wrap: 20 bytes through the 8-deep FIFO with overlapping push and pop
    doReset();
    for (int i = 0; i < 20; i++) begin
      pushCyc.push_back(4 * i);
      pushVal.push_back(8'(8'h10 + i));
      expBytes.push_back(8'(8'h10 + i));
    end
    runEcho(250, 2);
    checkStream("wrap");
    checkOutput("wrap max count <= 8", int'(maxCount <= 8), 1);
    checkOutput("wrap overrun", overrunSeen, 0);

    // Gap: low cycles between tx_done edge and next tx_en are GAP+2 (IDLE and LOAD)
    doReset();
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    n = 0;
    while (!txEn && n < 20) begin
      tick();
      n++;
    end
    checkOutput("gap first tx_en", txEn, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    lowA = 0;
    lowG = 0;
    seenA = 1'b0;
    seenG = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!seenA) begin
        if (txEn) seenA = 1'b1;
        else lowA++;
      end
      if (!seenG) begin
        if (txEnG) seenG = 1'b1;
        else lowG++;
      end
      tick();
    end
    checkOutput("gap0 low cycles", lowA, 2);
    checkOutput("gap4 low cycles", lowG, 6);
    checkOutput("gap0 second byte", txData, 8'h32);
    checkOutput("gap4 second byte", txDataG, 8'h32);

    // Reset in the middle of SEND with three bytes still queued
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h41 + k), 1'b0, 1'b0);
    checkOutput("midsend count", fifoCount, 3);
    checkOutput("midsend tx_en", txEn, 1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async rst tx_en", txEn, 0);
    checkOutput("async rst tx_data", txData, 8'h00);
    checkOutput("async rst fifo_count", fifoCount, 0);
    checkOutput("async rst overrun", overrun, 0);
    checkOutput("async rst rx_en", rxEn, 0);
    tick();
    tick();
    rstN = 1'b1;
    pushCyc.delete();
    pushVal.delete();
    expBytes.delete();
    runEcho(40, 2);
    checkOutput("post-reset no transmit", got.size(), 0);
    checkOutput("post-reset count", maxCount, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
